// File: rtl/set_time_ctrl.sv
// Push-button time setter: synchronised active-low keys step the h/m/s fields; output is seconds since midnight.
// Optional auto-repeat on the inc/dec keys is enabled by defining SET_TIME_AUTOREPEAT_EN.
module set_time_ctrl #(
    parameter int TIME_W        = 32,
    parameter int HOURS_PER_DAY = 24,
    parameter int SYNC_STAGES   = 2,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [2:0]        KEY,
    input  logic              on,
    input  logic              load,
    input  logic [TIME_W-1:0] load_time,
    output logic [TIME_W-1:0] user_time,
    output logic              finish,
    output logic [1:0]        stage
);

    typedef enum logic [1:0] {
        S_HOUR = 2'd0,
        S_MIN  = 2'd1,
        S_SEC  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [TIME_W-1:0] LP_DAY  = TIME_W'(HOURS_PER_DAY * 3600);
    localparam logic [4:0]        LP_HMAX = 5'(HOURS_PER_DAY - 1);

    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("set_time_ctrl: SYNC_STAGES must be at least 2");
    end
    if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 1) begin : g_chk_rpt
        $error("set_time_ctrl: REPEAT_DELAY must be >= 2 and REPEAT_PERIOD >= 1");
    end

    logic [SYNC_STAGES-1:0][2:0] r_sync;
    logic [2:0]                  r_prev;
    logic [2:0]                  r_evt;
    logic [2:0]                  w_key_s;
    logic [2:0]                  w_evt;
    state_t                      r_state;
    state_t                      w_state_nxt;
    logic                        r_finish;
    logic [4:0]                  r_h;
    logic [5:0]                  r_m;
    logic [5:0]                  r_s;
    logic [TIME_W-1:0]           r_user_time;
    logic [TIME_W-1:0]           w_ld_v;
    logic [TIME_W-1:0]           w_ld_rem;
    logic                        w_act;
    logic                        w_next;
    logic                        w_inc;
    logic                        w_dec;

    assign w_key_s = r_sync[SYNC_STAGES-1];

    // Preset to released so reset deassertion never looks like a press.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sync <= '1;
            r_prev <= '1;
            r_evt  <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], KEY};
            r_prev <= w_key_s;
            r_evt  <= r_prev & ~w_key_s;
        end
    end

`ifdef SET_TIME_AUTOREPEAT_EN
    logic [2:1] w_rpt;
    logic       w_rpt_clr;

    assign w_rpt_clr = ~on | load | (w_state_nxt != r_state);

    for (genvar k = 1; k <= 2; k++) begin : g_rpt
        logic [31:0] r_cnt;
        logic        r_active;
        logic        r_phase;
        logic        r_rpt;
        logic [31:0] w_lim;
        logic        w_hit;

        // First repeat after REPEAT_DELAY cycles, then every REPEAT_PERIOD.
        assign w_lim    = r_phase ? 32'(REPEAT_PERIOD) : 32'(REPEAT_DELAY);
        assign w_hit    = (r_cnt == w_lim - 32'd1);
        assign w_rpt[k] = r_rpt;

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                r_cnt    <= '0;
                r_active <= 1'b0;
                r_phase  <= 1'b0;
                r_rpt    <= 1'b0;
            end else if (w_rpt_clr || w_key_s[k]) begin
                r_cnt    <= '0;
                r_active <= 1'b0;
                r_phase  <= 1'b0;
                r_rpt    <= 1'b0;
            end else if (r_evt[k]) begin
                r_cnt    <= 32'd1;
                r_active <= 1'b1;
                r_phase  <= 1'b0;
                r_rpt    <= 1'b0;
            end else if (r_active) begin
                r_rpt <= w_hit;
                r_cnt <= w_hit ? '0 : r_cnt + 32'd1;
                if (w_hit) begin
                    r_phase <= 1'b1;
                end
            end else begin
                r_rpt <= 1'b0;
            end
        end
    end

    assign w_evt = r_evt | {w_rpt, 1'b0};
`else
    assign w_evt = r_evt;
`endif

    assign w_act  = on & ~load;
    assign w_next = w_act & w_evt[0];
    assign w_inc  = w_act & w_evt[1] & ~w_evt[2] & (r_state != S_DONE);
    assign w_dec  = w_act & w_evt[2] & ~w_evt[1] & (r_state != S_DONE);

    assign w_ld_v   = load_time % LP_DAY;
    assign w_ld_rem = w_ld_v % TIME_W'(3600);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= S_HOUR;
            r_finish <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_finish <= (w_state_nxt == S_DONE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (load) begin
            w_state_nxt = S_HOUR;
        end else if (w_next) begin
            case (r_state)
                S_HOUR:  w_state_nxt = S_MIN;
                S_MIN:   w_state_nxt = S_SEC;
                S_SEC:   w_state_nxt = S_DONE;
                default: w_state_nxt = S_HOUR;
            endcase
        end
    end

    always_comb begin
        stage     = r_state;
        finish    = r_finish;
        user_time = r_user_time;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_h <= '0;
            r_m <= '0;
            r_s <= '0;
        end else if (load) begin
            r_h <= 5'(w_ld_v / TIME_W'(3600));
            r_m <= 6'(w_ld_rem / TIME_W'(60));
            r_s <= 6'(w_ld_rem % TIME_W'(60));
        end else if (w_inc || w_dec) begin
            case (r_state)
                S_HOUR: r_h <= w_inc ? ((r_h == LP_HMAX) ? '0 : r_h + 5'd1)
                                     : ((r_h == '0) ? LP_HMAX : r_h - 5'd1);
                S_MIN:  r_m <= w_inc ? ((r_m == 6'd59) ? '0 : r_m + 6'd1)
                                     : ((r_m == '0) ? 6'd59 : r_m - 6'd1);
                S_SEC:  r_s <= w_inc ? ((r_s == 6'd59) ? '0 : r_s + 6'd1)
                                     : ((r_s == '0) ? 6'd59 : r_s - 6'd1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_user_time <= '0;
        end else begin
            r_user_time <= TIME_W'(r_h) * TIME_W'(3600) + TIME_W'(r_m) * TIME_W'(60) + TIME_W'(r_s);
        end
    end

endmodule

// File: tb/tb_set_time_ctrl.sv
// Directed and randomized checks of set_time_ctrl against an arithmetic h/m/s model.
module tb_set_time_ctrl;

    localparam int TW  = 32;
    localparam int SS  = 2;
    localparam int HPD = 24;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [2:0]    KEY = 3'b111;
    logic          on = 1'b0;
    logic          load = 1'b0;
    logic [TW-1:0] load_time = '0;
    logic [TW-1:0] user_time;
    logic          finish;
    logic [1:0]    stage;

    logic [2:0]    KEY12 = 3'b111;
    logic          load12 = 1'b0;
    logic [TW-1:0] lt12 = '0;
    logic [TW-1:0] ut12;
    logic          fin12;
    logic [1:0]    st12;

    int vectors = 0;
    int errors  = 0;
    int m_h = 0, m_m = 0, m_s = 0, m_st = 0;

    set_time_ctrl #(.TIME_W(TW), .HOURS_PER_DAY(HPD), .SYNC_STAGES(SS),
                    .REPEAT_DELAY(20), .REPEAT_PERIOD(5)) dut (
        .CLK(CLK), .RST(RST), .KEY(KEY), .on(on), .load(load), .load_time(load_time),
        .user_time(user_time), .finish(finish), .stage(stage));

    set_time_ctrl #(.TIME_W(TW), .HOURS_PER_DAY(12), .SYNC_STAGES(SS),
                    .REPEAT_DELAY(20), .REPEAT_PERIOD(5)) dut12 (
        .CLK(CLK), .RST(RST), .KEY(KEY12), .on(on), .load(load12), .load_time(lt12),
        .user_time(ut12), .finish(fin12), .stage(st12));

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint model_time();
        return longint'(m_h) * 3600 + longint'(m_m) * 60 + longint'(m_s);
    endfunction

    task automatic model_key(input logic [2:0] ev);
        if (!on) return;
        if (m_st != 3 && ev[1] != ev[2]) begin
            int d;
            d = ev[1] ? 1 : -1;
            case (m_st)
                0: m_h = (m_h + d + HPD) % HPD;
                1: m_m = (m_m + d + 60) % 60;
                default: m_s = (m_s + d + 60) % 60;
            endcase
        end
        if (ev[0]) m_st = (m_st + 1) % 4;
    endtask

    task automatic model_load(input logic [31:0] v);
        int r;
        r = int'(v % 32'(HPD * 3600));
        m_h = r / 3600;
        m_m = (r % 3600) / 60;
        m_s = r % 60;
        m_st = 0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Event pulse lands SS+1 edges after the fall; stage/fields one edge later, user_time one after that.
    task automatic press(input logic [2:0] ev, input string tag);
        int     old_st;
        longint old_t;
        old_st = m_st;
        old_t  = model_time();
        @(negedge CLK);
        KEY = ~ev;
        model_key(ev);
        repeat (SS + 1) tick();
        check({tag, ":stage_early"}, stage, old_st);
        tick();
        check({tag, ":stage"}, stage, m_st);
        check({tag, ":finish"}, finish, m_st == 3);
        check({tag, ":time_early"}, user_time, old_t);
        tick();
        check({tag, ":time"}, user_time, model_time());
        repeat (2) tick();
        @(negedge CLK);
        KEY = 3'b111;
        repeat (SS + 3) tick();
        check({tag, ":after_release"}, user_time, model_time());
    endtask

    task automatic do_load(input logic [31:0] v, input string tag);
        @(negedge CLK);
        load = 1'b1;
        load_time = v;
        @(negedge CLK);
        load = 1'b0;
        model_load(v);
        tick();
        check({tag, ":time"}, user_time, model_time());
        check({tag, ":stage"}, stage, 0);
        check({tag, ":finish"}, finish, 0);
    endtask

    initial begin
        #23;
        check("rst_time", user_time, 0);
        check("rst_stage", stage, 0);
        check("rst_finish", finish, 0);
        check("rst12_time", ut12, 0);
        @(negedge CLK);
        RST = 1'b0;
        on  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            check("idle_after_reset", {user_time, stage, finish}, 0);
        end

        on = 1'b1;
        repeat (3) press(3'b010, "hour_inc");
        press(3'b001, "next_min");
        repeat (2) press(3'b010, "min_inc");
        press(3'b001, "next_sec");
        press(3'b010, "sec_inc");
        check("sum_10921", user_time, 10921);
        check("sum_stage", stage, 2);

        do_load(7 * 3600 + 59 * 60, "ld_m59");
        press(3'b001, "to_min");
        press(3'b010, "min_wrap");
        check("min_wrap_val", user_time, 7 * 3600);

        do_load(5 * 3600 + 3 * 60, "ld_s0");
        press(3'b001, "to_min2");
        press(3'b001, "to_sec2");
        press(3'b100, "sec_wrap");
        check("sec_wrap_val", user_time, 5 * 3600 + 3 * 60 + 59);

        do_load(23 * 3600 + 5, "ld_h23");
        press(3'b010, "hour_wrap");
        check("hour_wrap_val", user_time, 5);

        press(3'b110, "inc_dec_same");
        check("inc_dec_val", user_time, 5);

        do_load(2 * 3600 + 10 * 60, "ld_nx");
        press(3'b001, "to_min3");
        press(3'b011, "next_with_inc");
        check("next_inc_stage", stage, 2);
        check("next_inc_val", user_time, 2 * 3600 + 11 * 60);

        do_load(0, "ld_zero");
        for (int i = 1; i <= 4; i++) begin
            press(3'b001, "four_next");
            check("four_next_finish", finish, i == 3);
        end

        on = 1'b0;
        press(3'b010, "off_inc");
        press(3'b001, "off_next");
        check("off_stage", stage, 0);
        check("off_val", user_time, 0);

        @(negedge CLK);
        KEY = 3'b101;
        repeat (6) tick();
        on = 1'b1;
        repeat (6) tick();
        KEY = 3'b111;
        repeat (6) tick();
        check("held_through_on", user_time, 0);

        press(3'b001, "pre_collide");
        @(negedge CLK);
        KEY = 3'b101;
        repeat (SS + 1) @(posedge CLK);
        @(negedge CLK);
        load = 1'b1;
        load_time = 90061;
        @(negedge CLK);
        load = 1'b0;
        model_load(90061);
        tick();
        check("collide_val", user_time, 3661);
        check("collide_stage", stage, 0);
        KEY = 3'b111;
        repeat (SS + 4) tick();
        check("collide_hold", user_time, model_time());

        @(negedge CLK);
        KEY12 = 3'b011;
        repeat (SS + 3) tick();
        check("h12_dec_wrap", ut12, 11 * 3600);
        KEY12 = 3'b111;
        @(negedge CLK);
        load12 = 1'b1;
        lt12 = 90061;
        @(negedge CLK);
        load12 = 1'b0;
        tick();
        check("h12_load_mod", ut12, 3661);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                do_load($urandom, "rnd_load");
            end else begin
                logic [2:0] ev;
                ev = 3'($urandom_range(1, 7));
                on = ($urandom_range(0, 4) != 0);
                press(ev, "rnd_press");
                on = 1'b1;
            end
        end

`ifdef SET_TIME_AUTOREPEAT_EN
        do_load(0, "ld_rpt");
        @(negedge CLK);
        KEY = 3'b101;
        repeat (41) @(posedge CLK);
        @(negedge CLK);
        KEY = 3'b111;
        repeat (10) tick();
        check("autorepeat_count", user_time, 6 * 3600);
`endif

        do_load(12345, "ld_prereset");
        @(negedge CLK);
        KEY = 3'b101;
        repeat (2) @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
        check("async_rst_time", user_time, 0);
        check("async_rst_stage", stage, 0);
        check("async_rst_finish", finish, 0);
        KEY = 3'b111;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        m_h = 0; m_m = 0; m_s = 0; m_st = 0;
        repeat (8) tick();
        check("post_rst_time", user_time, model_time());
        check("post_rst_stage", stage, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
